// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller and its score splitter.
package game_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    WON   = 2'd2,
    LOST  = 2'd3
  } game_state_t;

  localparam logic [1:0] SCR_TITLE = 2'd0;
  localparam logic [1:0] SCR_PLAY  = 2'd1;
  localparam logic [1:0] SCR_END   = 2'd2;

  localparam int SCORE_MAX = 999;

endpackage

// File: rtl/score_bcd_split.sv
// Iterative BCD split of a score (0..999): one subtraction of 100 or 10 per cycle.
// done is low while converting and high when the digits match the last value loaded.
module score_bcd_split
  import game_pkg::*;
#(
  parameter int SCORE_W = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] value,
  output logic [3:0]         hundreds,
  output logic [3:0]         tens,
  output logic [3:0]         ones,
  output logic               done
);

  typedef enum logic [1:0] {
    BCD_IDLE = 2'd0,
    BCD_HUND = 2'd1,
    BCD_TENS = 2'd2
  } bcd_phase_t;

  bcd_phase_t         phase_q, phase_d;
  logic [SCORE_W-1:0] work_q, work_d;
  logic [3:0]         hund_q, hund_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic               done_q, done_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase_q <= BCD_IDLE;
      work_q  <= '0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      done_q  <= 1'b1;
    end else begin
      phase_q <= phase_d;
      work_q  <= work_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end

  // Leaving the hundreds phase takes the first tens step in the same cycle,
  // so 999 needs 9 + 9 steps plus the final ones write.
  always_comb begin
    phase_d = phase_q;
    work_d  = work_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = done_q;
    case (phase_q)
      BCD_IDLE: ;
      BCD_HUND: begin
        if (32'(work_q) >= 100) begin
          work_d = work_q - SCORE_W'(100);
          hund_d = hund_q + 4'd1;
        end else if (32'(work_q) >= 10) begin
          work_d  = work_q - SCORE_W'(10);
          tens_d  = tens_q + 4'd1;
          phase_d = BCD_TENS;
        end else begin
          ones_d  = work_q[3:0];
          done_d  = 1'b1;
          phase_d = BCD_IDLE;
        end
      end
      BCD_TENS: begin
        if (32'(work_q) >= 10) begin
          work_d = work_q - SCORE_W'(10);
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d  = work_q[3:0];
          done_d  = 1'b1;
          phase_d = BCD_IDLE;
        end
      end
      default: phase_d = BCD_IDLE;
    endcase
    if (start) begin
      work_d  = value;
      hund_d  = 4'd0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      done_d  = 1'b0;
      phase_d = BCD_HUND;
    end
  end

  assign hundreds = hund_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign done     = done_q;

endmodule

// File: rtl/game_flow_controller.sv
// Title/play/end sequencer: gates gameplay, latches the final score and splits it into BCD.
// Define GAME_END_TIMEOUT_EN to return to title automatically after END_TIMEOUT_FRAMES ticks.
module game_flow_controller
  import game_pkg::*;
#(
  parameter logic [7:0] START_KEY          = 8'h2C,
  parameter int         END_HOLD_FRAMES    = 60,
  parameter int         SCORE_W            = 10,
  parameter int         END_TIMEOUT_FRAMES = 600
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [7:0]         keycode,
  input  logic               goal_reached,
  input  logic               player_dead,
  input  logic [SCORE_W-1:0] score_in,
  output logic               game_run,
  output logic [1:0]         screen_sel,
  output logic               is_won,
  output logic               is_lost,
  output logic [SCORE_W-1:0] final_score,
  output logic [3:0]         score_hundreds,
  output logic [3:0]         score_tens,
  output logic [3:0]         score_ones,
  output logic               digits_valid
);

  localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);

  game_state_t        state_q, state_d;
  logic               sync1_q, sync2_q, sync_prev_q, tick_q;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               armed_q, armed_d;
  logic [SCORE_W-1:0] final_q, final_d;
  logic               game_run_q, game_run_d;
  logic [1:0]         screen_q, screen_d;
  logic               won_q, won_d;
  logic               lost_q, lost_d;
  logic               key_start, hold_sat, in_end, enter_end, timeout_hit;
  logic [SCORE_W-1:0] sat_score;

  // frame_clk is asynchronous to Clk; synchronize, then pulse once per rising edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      sync1_q     <= frame_clk;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      tick_q      <= sync2_q & ~sync_prev_q;
    end
  end

  assign key_start = armed_q && (keycode == START_KEY);
  assign hold_sat  = (hold_q == HOLD_W'(END_HOLD_FRAMES));
  assign in_end    = (state_q == WON) || (state_q == LOST);
  assign sat_score = (32'(score_in) > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : score_in;

`ifdef GAME_END_TIMEOUT_EN
  localparam int TO_W = $clog2(END_TIMEOUT_FRAMES + 1);
  logic [TO_W-1:0] timeout_q, timeout_d;

  assign timeout_hit = in_end && tick_q && (timeout_q == TO_W'(END_TIMEOUT_FRAMES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) timeout_q <= '0;
    else       timeout_q <= timeout_d;
  end

  always_comb begin
    timeout_d = timeout_q;
    if (enter_end)          timeout_d = '0;
    else if (in_end && tick_q) timeout_d = timeout_q + TO_W'(1);
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (END_TIMEOUT_FRAMES > 0);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= TITLE;
      hold_q     <= '0;
      armed_q    <= 1'b0;
      final_q    <= '0;
      game_run_q <= 1'b0;
      screen_q   <= SCR_TITLE;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      armed_q    <= armed_d;
      final_q    <= final_d;
      game_run_q <= game_run_d;
      screen_q   <= screen_d;
      won_q      <= won_d;
      lost_q     <= lost_d;
    end
  end

  // Outputs decode state_d so they are registered alongside the state itself.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TITLE: if (key_start) state_d = PLAY;
      PLAY: begin
        if (player_dead)       state_d = LOST;
        else if (goal_reached) state_d = WON;
      end
      WON, LOST: begin
        if (hold_sat && key_start) state_d = TITLE;
        else if (timeout_hit)      state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase

    enter_end = (state_q == PLAY) && ((state_d == WON) || (state_d == LOST));

    hold_d = hold_q;
    if (enter_end)                       hold_d = '0;
    else if (in_end && tick_q && !hold_sat) hold_d = hold_q + HOLD_W'(1);

    // Any state change disarms the key so a held START_KEY cannot chain transitions.
    armed_d = armed_q;
    if (state_d != state_q)        armed_d = 1'b0;
    else if (keycode != START_KEY) armed_d = 1'b1;

    final_d = enter_end ? sat_score : final_q;

    game_run_d = (state_d == PLAY);
    won_d      = (state_d == WON);
    lost_d     = (state_d == LOST);
    case (state_d)
      TITLE:   screen_d = SCR_TITLE;
      PLAY:    screen_d = SCR_PLAY;
      default: screen_d = SCR_END;
    endcase
  end

  score_bcd_split #(
    .SCORE_W (SCORE_W)
  ) u_bcd (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (enter_end),
    .value    (sat_score),
    .hundreds (score_hundreds),
    .tens     (score_tens),
    .ones     (score_ones),
    .done     (digits_valid)
  );

  assign game_run    = game_run_q;
  assign screen_sel  = screen_q;
  assign is_won      = won_q;
  assign is_lost     = lost_q;
  assign final_score = final_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed self-checking bench for game_flow_controller; honours GAME_END_TIMEOUT_EN.
module tb_game_flow_controller;

`ifdef GAME_END_TIMEOUT_EN
  localparam int TO_FRAMES = 5;
`else
  localparam int TO_FRAMES = 600;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       goal_reached;
  logic       player_dead;
  logic [9:0] score_in;
  logic       game_run;
  logic [1:0] screen_sel;
  logic       is_won;
  logic       is_lost;
  logic [9:0] final_score;
  logic [3:0] score_hundreds, score_tens, score_ones;
  logic       digits_valid;

  int testsRun = 0;
  int testsFailed = 0;

  game_flow_controller #(
    .START_KEY          (8'h2C),
    .END_HOLD_FRAMES    (60),
    .SCORE_W            (10),
    .END_TIMEOUT_FRAMES (TO_FRAMES)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_clk      (frame_clk),
    .keycode        (keycode),
    .goal_reached   (goal_reached),
    .player_dead    (player_dead),
    .score_in       (score_in),
    .game_run       (game_run),
    .screen_sel     (screen_sel),
    .is_won         (is_won),
    .is_lost        (is_lost),
    .final_score    (final_score),
    .score_hundreds (score_hundreds),
    .score_tens     (score_tens),
    .score_ones     (score_ones),
    .digits_valid   (digits_valid)
  );

  always #5 Clk = ~Clk;

  task automatic stepCycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] key, input logic goal, input logic dead,
                               input logic [9:0] score, input int cycles);
    keycode      = key;
    goal_reached = goal;
    player_dead  = dead;
    score_in     = score;
    stepCycles(cycles);
  endtask

  task automatic applyFrameTicks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      stepCycles(4);
      frame_clk = 1'b0;
      stepCycles(4);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic waitDigits(input string tag);
    int n;
    n = 0;
    while (digits_valid !== 1'b1 && n < 20) begin
      stepCycles(1);
      n++;
    end
    checkOutput(tag, digits_valid, 1);
  endtask

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'h00;
    goal_reached = 1'b0;
    player_dead = 1'b0;
    score_in = 10'd0;
    stepCycles(3);
    Reset = 1'b0;
    stepCycles(10);
    checkOutput("rst_screen", screen_sel, 0);
    checkOutput("rst_run", game_run, 0);
    checkOutput("rst_won", is_won, 0);
    checkOutput("rst_lost", is_lost, 0);
    checkOutput("rst_final", final_score, 0);
    checkOutput("rst_digits", {score_hundreds, score_tens, score_ones}, 0);
    checkOutput("rst_valid", digits_valid, 1);

    // Start from title: release, then press.
    applyStimulus(8'h00, 0, 0, 10'd0, 1);
    checkOutput("title_before_press", screen_sel, 0);
    applyStimulus(8'h2C, 0, 0, 10'd0, 1);
    checkOutput("play_run", game_run, 1);
    checkOutput("play_screen", screen_sel, 1);

    // Win with 347 while START_KEY stays held.
    applyStimulus(8'h2C, 1, 0, 10'd347, 1);
    checkOutput("won_flag", is_won, 1);
    checkOutput("won_run", game_run, 0);
    checkOutput("won_screen", screen_sel, 2);
    checkOutput("won_final", final_score, 347);
    checkOutput("won_valid_drop", digits_valid, 0);
    applyStimulus(8'h2C, 0, 0, 10'd0, 0);
    waitDigits("won_valid_rise");
    checkOutput("won_hundreds", score_hundreds, 3);
    checkOutput("won_tens", score_tens, 4);
    checkOutput("won_ones", score_ones, 7);

`ifdef GAME_END_TIMEOUT_EN
    applyFrameTicks(5);
    checkOutput("won_timeout_title", screen_sel, 0);
    checkOutput("held_key_no_start", game_run, 0);
`else
    applyFrameTicks(61);
    checkOutput("held_key_stays_won", is_won, 1);
    applyStimulus(8'h00, 0, 0, 10'd0, 1);
    applyStimulus(8'h2C, 0, 0, 10'd0, 1);
    checkOutput("won_restart_title", screen_sel, 0);
    checkOutput("won_restart_flag", is_won, 0);
`endif
    checkOutput("title_keeps_final", final_score, 347);
    checkOutput("title_keeps_ones", score_ones, 7);

    applyStimulus(8'h00, 0, 0, 10'd0, 1);
    applyStimulus(8'h2C, 0, 0, 10'd0, 1);
    checkOutput("play2_run", game_run, 1);
    checkOutput("play_keeps_final", final_score, 347);

    // Simultaneous goal and death with an over-range score.
    applyStimulus(8'h00, 1, 1, 10'd1023, 1);
    checkOutput("lost_flag", is_lost, 1);
    checkOutput("lost_not_won", is_won, 0);
    checkOutput("lost_final_sat", final_score, 999);
    checkOutput("lost_valid_drop", digits_valid, 0);
    applyStimulus(8'h00, 0, 0, 10'd0, 0);
    waitDigits("lost_valid_rise");
    checkOutput("lost_digits_999", {score_hundreds, score_tens, score_ones}, 32'h999);

`ifdef GAME_END_TIMEOUT_EN
    applyFrameTicks(4);
    checkOutput("lost_before_timeout", is_lost, 1);
    frame_clk = 1'b1;
    stepCycles(3);
    checkOutput("lost_at_5th_tick", is_lost, 1);
    stepCycles(1);
    checkOutput("timeout_title", screen_sel, 0);
    checkOutput("timeout_lost_clear", is_lost, 0);
    frame_clk = 1'b0;
    stepCycles(4);
`else
    applyFrameTicks(59);
    applyStimulus(8'h2C, 0, 0, 10'd0, 1);
    checkOutput("press_at_59_stays", is_lost, 1);
    applyStimulus(8'h00, 0, 0, 10'd0, 1);
    applyFrameTicks(1);
    checkOutput("no_timeout_lost", is_lost, 1);
    applyStimulus(8'h2C, 0, 0, 10'd0, 1);
    checkOutput("press_at_60_title", screen_sel, 0);
    checkOutput("press_at_60_lost_clear", is_lost, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
